// File: rtl/traffic_pkg.sv
// Shared light encoding used by the traffic-light controller and the
// intersection environment model.
package traffic_pkg;

  typedef logic [1:0] light_t;

  localparam light_t GREEN   = 2'b00;
  localparam light_t YELLOW  = 2'b01;
  localparam light_t RED     = 2'b10;
  localparam light_t ILLEGAL = 2'b11;

endpackage

// File: rtl/street_queue.sv
// One street of the intersection: a saturating car counter, a departure
// timer that releases one car per DEPART_CYCLES green cycles, and a sensor.
module street_queue
  import traffic_pkg::*;
#(
  parameter int QW            = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arrive,
  input  light_t        light,
  output logic          sensor,
  output logic [QW-1:0] count,
  output logic          drop
);

  localparam logic [QW-1:0] FULL    = '1;
  localparam logic [3:0]    DT_LAST = 4'(DEPART_CYCLES - 1);

  logic [3:0] dt;
  logic       active;
  logic       dep;

  // The timer only runs while the light is green and somebody is waiting.
  assign active = (light == GREEN) && (count != '0);
  assign dep    = active && (dt == DT_LAST);

  function automatic logic [QW-1:0] next_count(input logic [QW-1:0] c,
                                               input logic          inc,
                                               input logic          dec);
    logic [QW-1:0] r;
    r = c;
    if (inc && !dec && (c != FULL)) r = c + 1'b1;
    else if (dec && !inc)           r = c - 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      dt    <= '0;
      drop  <= 1'b0;
    end else begin
      count <= next_count(count, arrive, dep);
      dt    <= (!active || dep) ? 4'd0 : dt + 4'd1;
      // A simultaneous departure frees the slot, so a full queue loses nothing.
      if (arrive && !dep && (count == FULL)) drop <= 1'b1;
    end
  end

  assign sensor = (count != '0);

endmodule

// File: rtl/traffic_sensor.sv
// Intersection environment: two street queues feeding the Ta/Tb sensors
// plus a sticky safety monitor on the LA/LB light pair.
module traffic_sensor
  import traffic_pkg::*;
#(
  parameter int QW            = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arrive_a,
  input  logic          arrive_b,
  input  light_t        LA,
  input  light_t        LB,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] count_a,
  output logic [QW-1:0] count_b,
  output logic          drop_a,
  output logic          drop_b,
  output logic          conflict
);

  logic unsafe;

  street_queue #(.QW(QW), .DEPART_CYCLES(DEPART_CYCLES)) u_street_a (
    .clk    (clk),
    .reset  (reset),
    .arrive (arrive_a),
    .light  (LA),
    .sensor (Ta),
    .count  (count_a),
    .drop   (drop_a)
  );

  street_queue #(.QW(QW), .DEPART_CYCLES(DEPART_CYCLES)) u_street_b (
    .clk    (clk),
    .reset  (reset),
    .arrive (arrive_b),
    .light  (LB),
    .sensor (Tb),
    .count  (count_b),
    .drop   (drop_b)
  );

  // Unsafe means an undefined light code or neither street held at red.
  assign unsafe = (LA == ILLEGAL) || (LB == ILLEGAL) ||
                  ((LA != RED) && (LB != RED));

  always_ff @(posedge clk) begin
    if (reset)       conflict <= 1'b0;
    else if (unsafe) conflict <= 1'b1;
  end

endmodule

// File: tb/tb_traffic_sensor.sv
// Scoreboard bench for traffic_sensor: two instances (DEPART_CYCLES 2 and 3)
// share stimulus and are checked against a behavioural intersection model.
module tb_traffic_sensor;

  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, X = 2'b11;
  localparam int CAP = 15;

  typedef struct packed {
    logic       ta, tb;
    logic [3:0] ca, cb;
    logic       da, db, cf;
  } obs_t;

  typedef struct {
    obs_t o[2];
  } exp_t;

  logic       clk = 1'b1;
  logic       reset = 1'b0, arrive_a = 1'b0, arrive_b = 1'b0;
  logic [1:0] LA = R, LB = R;

  logic       ta2, tb2, da2, db2, cf2, ta3, tb3, da3, db3, cf3;
  logic [3:0] ca2, cb2, ca3, cb3;

  int total = 0;
  int bad = 0;
  exp_t q[$];

  // Model state: [instance][street], instance 0 departs every 2, 1 every 3.
  int cnt[2][2];
  int run[2][2];
  bit drp[2][2];
  bit conf;
  int dcyc[2] = '{2, 3};

  always #5 clk = ~clk;

  traffic_sensor #(.QW(4), .DEPART_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .arrive_a(arrive_a), .arrive_b(arrive_b),
    .LA(LA), .LB(LB), .Ta(ta2), .Tb(tb2), .count_a(ca2), .count_b(cb2),
    .drop_a(da2), .drop_b(db2), .conflict(cf2)
  );

  traffic_sensor #(.QW(4), .DEPART_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .arrive_a(arrive_a), .arrive_b(arrive_b),
    .LA(LA), .LB(LB), .Ta(ta3), .Tb(tb3), .count_a(ca3), .count_b(cb3),
    .drop_a(da3), .drop_b(db3), .conflict(cf3)
  );

  task automatic model_street(input int i, input int s, input bit r,
                              input bit arr, input logic [1:0] lt);
    bit waiting, dep;
    if (r) begin
      cnt[i][s] = 0; run[i][s] = 0; drp[i][s] = 1'b0;
      return;
    end
    // A car leaves on every D-th consecutive green cycle with cars waiting.
    waiting = (lt == G) && (cnt[i][s] > 0);
    dep     = waiting && (((run[i][s] + 1) % dcyc[i]) == 0);
    run[i][s] = waiting ? run[i][s] + 1 : 0;
    if (arr && !dep) begin
      if (cnt[i][s] == CAP) drp[i][s] = 1'b1;
      else cnt[i][s]++;
    end else if (dep && !arr) begin
      cnt[i][s]--;
    end
  endtask

  task automatic step(input bit r, input bit aa, input bit ab,
                      input logic [1:0] la, input logic [1:0] lb);
    exp_t e;
    @(negedge clk);
    reset = r; arrive_a = aa; arrive_b = ab; LA = la; LB = lb;
    for (int i = 0; i < 2; i++) begin
      model_street(i, 0, r, aa, la);
      model_street(i, 1, r, ab, lb);
    end
    if (r) conf = 1'b0;
    else if (la == X || lb == X || (la != R && lb != R)) conf = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e.o[i].ta = (cnt[i][0] != 0);
      e.o[i].tb = (cnt[i][1] != 0);
      e.o[i].ca = 4'(cnt[i][0]);
      e.o[i].cb = 4'(cnt[i][1]);
      e.o[i].da = drp[i][0];
      e.o[i].db = drp[i][1];
      e.o[i].cf = conf;
    end
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input int inst, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", nm, inst, got, want, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, one expected entry per edge.
  always @(posedge clk) begin
    exp_t e;
    obs_t g[2];
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      g[0] = '{ta2, tb2, ca2, cb2, da2, db2, cf2};
      g[1] = '{ta3, tb3, ca3, cb3, da3, db3, cf3};
      for (int i = 0; i < 2; i++) begin
        cmp("Ta", i, int'(g[i].ta), int'(e.o[i].ta));
        cmp("Tb", i, int'(g[i].tb), int'(e.o[i].tb));
        cmp("count_a", i, int'(g[i].ca), int'(e.o[i].ca));
        cmp("count_b", i, int'(g[i].cb), int'(e.o[i].cb));
        cmp("drop_a", i, int'(g[i].da), int'(e.o[i].da));
        cmp("drop_b", i, int'(g[i].db), int'(e.o[i].db));
        cmp("conflict", i, int'(g[i].cf), int'(e.o[i].cf));
      end
    end
  end

  initial begin
    int ph, len;
    logic [1:0] la, lb;

    // Reset beats a simultaneous arrival, then one arrival shows up next edge.
    step(1, 1, 0, R, R);
    step(0, 1, 0, R, R);
    step(0, 0, 0, R, R);

    // Three cars on A drained by a six-cycle green.
    step(1, 0, 0, R, R);
    repeat (3) step(0, 1, 0, R, R);
    repeat (6) step(0, 0, 0, G, R);
    step(0, 0, 0, R, R);

    // Fill A, overflow once, then green with a car arriving every cycle.
    step(1, 0, 0, R, R);
    repeat (16) step(0, 1, 0, R, R);
    repeat (8) step(0, 1, 0, G, R);
    step(0, 0, 0, R, R);

    // Green interrupted by yellow: the partial interval is discarded.
    step(1, 0, 0, R, R);
    repeat (2) step(0, 1, 0, R, R);
    repeat (2) step(0, 0, 0, G, R);
    repeat (2) step(0, 0, 0, Y, R);
    repeat (5) step(0, 0, 0, G, R);

    // Conflicting lights, then an illegal code from a fresh reset.
    step(1, 0, 0, R, R);
    step(0, 0, 0, G, Y);
    repeat (3) step(0, 0, 0, R, G);
    step(1, 0, 0, R, R);
    step(0, 0, 0, X, R);
    repeat (2) step(0, 0, 0, R, R);

    // Reset in the middle of a B departure interval with drop_b set.
    step(1, 0, 0, R, R);
    repeat (16) step(0, 0, 1, R, R);
    repeat (21) step(0, 0, 0, R, G);
    step(1, 0, 0, R, G);
    repeat (7) step(0, 0, 1, R, G);

    // Randomised light phases, arrivals and occasional resets.
    step(1, 0, 0, R, R);
    for (int n = 0; n < 300; n++) begin
      ph  = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      case (ph)
        0, 1, 2: begin la = G; lb = R; end
        3, 4, 5: begin la = R; lb = G; end
        6:       begin la = Y; lb = R; end
        7:       begin la = R; lb = Y; end
        8:       begin la = R; lb = R; end
        default: begin la = 2'($urandom_range(0, 3)); lb = 2'($urandom_range(0, 3)); len = 1; end
      endcase
      for (int c = 0; c < len; c++)
        step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 9) < 4), la, lb);
      if (ph == 9) step(1, $urandom_range(0, 1), $urandom_range(0, 1), R, R);
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_sensor.md
# traffic_sensor

Intersection environment model that closes the loop around the traffic-light Moore FSM. It consumes the light outputs LA/LB and per-street car-arrival pulses, keeps a vehicle queue per street, and drives the Ta/Tb traffic sensors back into the controller. It also runs a sticky safety monitor on the light pair, so one instance gives the controller both stimulus and checking in simulation and on the board.

## Interface
- QW, 4: width of each per-street queue counter; capacity is 2^QW-1 cars.
- DEPART_CYCLES, 2: consecutive green cycles needed to release one car; legal range 1..15.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- arrive_a  input  1  one car arrives on street A this cycle.
- arrive_b  input  1  one car arrives on street B this cycle.
- LA  input  2  street A light from the controller.
- LB  input  2  street B light from the controller.
- Ta  output  1  street A sensor; high when count_a != 0.
- Tb  output  1  street B sensor; high when count_b != 0.
- count_a  output  QW  cars queued on A.
- count_b  output  QW  cars queued on B.
- drop_a  output  1  sticky; an arrival on A was lost because the queue was full.
- drop_b  output  1  sticky; same for B.
- conflict  output  1  sticky; a light-safety violation was seen.

## Operation
- Light encoding: GREEN=2'b00, YELLOW=2'b01, RED=2'b10. 2'b11 is illegal.
- Each street runs an independent queue with the same rules. Street A is described here. Street B is identical using arrive_b, LB, Tb and drop_b.
- Departure timer dt_a is 4 bits wide.
  - It is cleared in every cycle where LA != GREEN, and in every cycle where count_a == 0.
  - Otherwise it increments each cycle.
  - When dt_a == DEPART_CYCLES-1, dep_a is asserted for that cycle and dt_a is reloaded to 0.
- Cars leave only on GREEN. No car leaves on YELLOW.
- Count update per cycle, using inc = arrive_a and dec = dep_a:
  - inc only: count +1, except when count is full (all ones). When full, the count holds and drop_a is set.
  - dec only: count -1. dec can never occur when count is 0.
  - inc and dec together: count unchanged. No drop occurs, even when the count is full.
  - neither: hold.
- Ta = (count_a != 0), decoded from the registered count. Ta is therefore glitch-free and Moore-style.
- Safety monitor: conflict is set in any cycle where one of the following holds:
  - LA == 2'b11 or LB == 2'b11;
  - LA != RED and LB != RED at the same time.
- conflict, drop_a and drop_b clear only on reset.

## Timing
- Reset values: all counts 0, Ta=0, Tb=0, dt_a=dt_b=0, drop_a=drop_b=0, conflict=0.
- Reset has priority over every other input in the same cycle, including arrivals sampled that cycle.
- Arrival to sensor: arrive_a high before edge k gives count_a+1 and Ta=1 after edge k. Latency is 1 clock.
- Departure: LA goes GREEN with count_a>0 before edge k. The first car leaves at edge k+DEPART_CYCLES-1. Each further car leaves every DEPART_CYCLES edges while LA stays GREEN.
- Leaving GREEN mid-interval discards the partial interval. The timer restarts from 0 on the next GREEN.
- The sticky flags are set at the edge after the offending input is sampled. They are visible 1 cycle later.
- Reset asserted mid-operation: every register takes its reset value at that edge, with no partial update.
- Inputs are synchronous to clk. No synchronizers are included.

## Structure
- Shared package traffic_pkg holds:
  - the light constants GREEN, YELLOW, RED;
  - a light_t 2-bit typedef.
  - The controller FSM imports the same package so both ends share one encoding.
- Sub-module street_queue holds one counter, one timer, the drop flag and the sensor decode. It takes parameters QW and DEPART_CYCLES and is instantiated twice.
- The conflict monitor lives in the top level traffic_sensor.

## Test plan
- Reset with arrive_a pulsed in the same cycle: count_a=0, Ta=0 and all flags 0 after the edge. Release reset and pulse arrive_a once: count_a=1 and Ta=1 one cycle later.
- LA=RED, 3 arrivals on A, then LA=GREEN held for 6 cycles with DEPART_CYCLES=2: count_a steps 3→2→1→0 on green cycles 2, 4 and 6. Ta falls with the last step.
- Fill A to 15 with LA=RED, then one more arrival: count_a stays 15 and drop_a=1. Then LA=GREEN with arrive_a held high every cycle: count_a holds at 15 on each departure edge and no new drop is flagged.
- LA=GREEN, count_a=2, DEPART_CYCLES=3; switch LA to YELLOW after 2 green cycles, then back to GREEN: no departure during YELLOW. The first departure comes 3 cycles after GREEN returns.
- LA=GREEN with LB=YELLOW for 1 cycle gives conflict=1, which persists after the lights return to legal values. Repeat from reset with LA=2'b11: conflict=1.
- Assert reset mid-way through a departure interval with count_b=5 and drop_b=1: all outputs return to their reset values at that edge. The next GREEN starts a full DEPART_CYCLES interval.
